motion_update_broadcaster: RTL

Transmit side of the motion-update broadcast bus that every position cache listens to. On a start pulse, the block does the following:

- Scans every cell's active position buffer and the matching displacement buffer.
- Adds displacement to position with periodic wrap-around.
- Broadcasts each new position with its destination cell ID, holding the enable high for the whole sweep.

It sits in RL_LJ_Top beside the cell array. The top level muxes the read ports of the selected cell onto `in_pos_data` / `in_disp_data`.

---
 rtl/motion_update_broadcaster_if.sv | 35 +++
 rtl/motion_update_broadcaster.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/motion_update_broadcaster_if.sv
// Motion-update broadcast bus: cell-memory read port toward the selected cell
// plus the broadcast channel every position cache listens to.
interface motion_update_broadcaster_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4
);
  logic                       start;
  logic [3*CELL_ID_WIDTH-1:0] out_rd_cell;
  logic [ADDR_WIDTH-1:0]      out_rd_address;
  logic                       out_rden;
  logic [3*DATA_WIDTH-1:0]    in_pos_data;
  logic [3*DATA_WIDTH-1:0]    in_disp_data;
  logic                       out_motion_update_enable;
  logic [3*DATA_WIDTH-1:0]    out_data;
  logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell;
  logic                       out_data_valid;
  logic                       out_done;

  // Broadcaster side
  modport master (
    input  start, in_pos_data, in_disp_data,
    output out_rd_cell, out_rd_address, out_rden,
           out_motion_update_enable, out_data, out_data_dst_cell,
           out_data_valid, out_done
  );

  // Cell array / top-level side
  modport slave (
    output start, in_pos_data, in_disp_data,
    input  out_rd_cell, out_rd_address, out_rden,
           out_motion_update_enable, out_data, out_data_dst_cell,
           out_data_valid, out_done
  );
endinterface

// File: rtl/motion_update_broadcaster.sv
// Motion-update broadcaster: sweeps every cell (z fastest, then y, then x),
// reads each particle's position and displacement, applies periodic
// wrap-around and broadcasts the new position with its destination cell.
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_NUM_X    = 4,
  parameter int CELL_NUM_Y    = 2,
  parameter int CELL_NUM_Z    = 2
) (
  input logic clk,
  input logic rst,
  motion_update_broadcaster_if.master bus
);

  localparam int FRAC_WIDTH = DATA_WIDTH - CELL_ID_WIDTH;

  localparam logic [CELL_ID_WIDTH-1:0] NX = CELL_ID_WIDTH'(CELL_NUM_X);
  localparam logic [CELL_ID_WIDTH-1:0] NY = CELL_ID_WIDTH'(CELL_NUM_Y);
  localparam logic [CELL_ID_WIDTH-1:0] NZ = CELL_ID_WIDTH'(CELL_NUM_Z);
  localparam logic [CELL_ID_WIDTH-1:0] ONE = CELL_ID_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    RD_PART,
    DRAIN,
    NEXT_CELL,
    FLUSH,
    CLOSE
  } state_t;

  state_t state;

  logic [CELL_ID_WIDTH-1:0] cx, cy, cz;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [ADDR_WIDTH-1:0]    count;
  logic [1:0]               close_cnt;
  logic                     rden;
  logic                     enable;
  logic                     done;
  logic                     last_cell;

  // Datapath
  logic                       data_phase;
  logic [DATA_WIDTH-1:0]      new_x, new_y, new_z;
  logic [3*DATA_WIDTH-1:0]    new_data;
  logic [3*CELL_ID_WIDTH-1:0] new_dst;
  logic [3*DATA_WIDTH-1:0]    data;
  logic [3*CELL_ID_WIDTH-1:0] dst;
  logic                       valid;

  // Sum modulo 2^DATA_WIDTH, then fold coordinate 0 / n+1 back into 1..n.
  // Displacement is below one cell, so a single correction always suffices.
  function automatic logic [DATA_WIDTH-1:0] wrap_axis(
    input logic [DATA_WIDTH-1:0]    pos,
    input logic [DATA_WIDTH-1:0]    disp,
    input logic [CELL_ID_WIDTH-1:0] n
  );
    logic [DATA_WIDTH-1:0]    sum;
    logic [DATA_WIDTH-1:0]    span;
    logic [CELL_ID_WIDTH-1:0] field;
    sum   = pos + disp;
    field = sum[DATA_WIDTH-1 -: CELL_ID_WIDTH];
    span  = {n, {FRAC_WIDTH{1'b0}}};
    if (field == '0) begin
      wrap_axis = sum + span;
    end else if (field == n + ONE) begin
      wrap_axis = sum - span;
    end else begin
      wrap_axis = sum;
    end
  endfunction

  assign last_cell = (cx == NX) && (cy == NY) && (cz == NZ);

  // New position and destination cell from the data returned by the memory
  always_comb begin
    new_x    = wrap_axis(bus.in_pos_data[DATA_WIDTH-1:0],
                         bus.in_disp_data[DATA_WIDTH-1:0], NX);
    new_y    = wrap_axis(bus.in_pos_data[2*DATA_WIDTH-1:DATA_WIDTH],
                         bus.in_disp_data[2*DATA_WIDTH-1:DATA_WIDTH], NY);
    new_z    = wrap_axis(bus.in_pos_data[3*DATA_WIDTH-1:2*DATA_WIDTH],
                         bus.in_disp_data[3*DATA_WIDTH-1:2*DATA_WIDTH], NZ);
    new_data = {new_z, new_y, new_x};
    new_dst  = {new_x[DATA_WIDTH-1 -: CELL_ID_WIDTH],
                new_y[DATA_WIDTH-1 -: CELL_ID_WIDTH],
                new_z[DATA_WIDTH-1 -: CELL_ID_WIDTH]};
  end

  // Sweep controller with registered read-port, enable and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      cz        <= '0;
      addr      <= '0;
      count     <= '0;
      close_cnt <= '0;
      rden      <= 1'b0;
      enable    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cx     <= ONE;
            cy     <= ONE;
            cz     <= ONE;
            addr   <= '0;
            rden   <= 1'b1;
            enable <= 1'b1;
            state  <= RD_CNT;
          end
        end
        RD_CNT: begin
          rden  <= 1'b0;
          state <= WAIT_CNT;
        end
        WAIT_CNT: begin
          count <= bus.in_pos_data[ADDR_WIDTH-1:0];
          if (bus.in_pos_data[ADDR_WIDTH-1:0] == '0) begin
            state <= NEXT_CELL;
          end else begin
            addr  <= ADDR_WIDTH'(1);
            rden  <= 1'b1;
            state <= RD_PART;
          end
        end
        RD_PART: begin
          if (addr == count) begin
            rden  <= 1'b0;
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          state <= NEXT_CELL;
        end
        NEXT_CELL: begin
          if (last_cell) begin
            state <= FLUSH;
          end else begin
            if (cz == NZ) begin
              cz <= ONE;
              if (cy == NY) begin
                cy <= ONE;
                cx <= cx + 1'b1;
              end else begin
                cy <= cy + 1'b1;
              end
            end else begin
              cz <= cz + 1'b1;
            end
            addr  <= '0;
            rden  <= 1'b1;
            state <= RD_CNT;
          end
        end
        FLUSH: begin
          enable    <= 1'b0;
          close_cnt <= '0;
          state     <= CLOSE;
        end
        CLOSE: begin
          if (close_cnt == 2'd2) begin
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            addr      <= '0;
            count     <= '0;
            close_cnt <= '0;
            state     <= IDLE;
          end else begin
            close_cnt <= close_cnt + 2'd1;
            if (close_cnt == 2'd1) begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Broadcast register stage: data returned for a particle read is launched
  // the following cycle, two cycles after its rden; address 0 is the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_phase <= 1'b0;
      valid      <= 1'b0;
      data       <= '0;
      dst        <= '0;
    end else begin
      data_phase <= rden && (addr != '0);
      valid      <= data_phase;
      data       <= data_phase ? new_data : '0;
      dst        <= data_phase ? new_dst  : '0;
    end
  end

  assign bus.out_rd_cell              = {cx, cy, cz};
  assign bus.out_rd_address           = addr;
  assign bus.out_rden                 = rden;
  assign bus.out_motion_update_enable = enable;
  assign bus.out_data                 = data;
  assign bus.out_data_dst_cell        = dst;
  assign bus.out_data_valid           = valid;
  assign bus.out_done                 = done;

endmodule
